// File: rtl/reg_file_sb.sv
// reg_file_sb
// Decode-stage register file: two combinational read ports, two prioritised
// write ports (ALU writeback WE0/WN0/WD0 beats memory writeback WE1/WN1/WD1),
// optional same-cycle write-to-read bypass and a per-register busy scoreboard
// used for load-use hazard detection.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   RN1, RN2          read addresses
//   RD1, RD2          read data (combinational)
//   Busy1, Busy2      scoreboard bit of RN1 / RN2 (combinational)
//   WE0, WN0, WD0     write port 0, high priority
//   WE1, WN1, WD1     write port 1, low priority
//   Mark, MN          set busy bit of register MN
//   Ready             high once the post-reset clearing walk has finished
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RN1,
  input  logic [ADDR_W-1:0] RN2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WN0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WN1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              Mark,
  input  logic [ADDR_W-1:0] MN,
  output logic              Ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic run;
  logic we0Eff;
  logic we1Eff;
  logic markEff;

  // Port 1 is suppressed when port 0 targets the same register, so the
  // storage never sees two writes to one entry in the same cycle.
  always_comb begin
    run     = (state_q == RUN);
    we0Eff  = run & WE0 & (WN0 != '0);
    we1Eff  = run & WE1 & (WN1 != '0) & ~(we0Eff & (WN1 == WN0));
    markEff = run & Mark & (MN != '0);
  end

  // Clearing walk: one entry per edge, the last entry moves us to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = RUN;
      end
    end
  end

  // Mark is applied last so it wins over a same-cycle write to the register.
  always_comb begin
    busy_d = busy_q;
    if (we1Eff) begin
      busy_d[WN1] = 1'b0;
    end
    if (we0Eff) begin
      busy_d[WN0] = 1'b0;
    end
    if (markEff) begin
      busy_d[MN] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset of its own; it is cleared by the INIT walk and left
  // untouched while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (we1Eff) begin
          mem_q[WN1] <= WD1;
        end
        if (we0Eff) begin
          mem_q[WN0] <= WD0;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] rn);
    logic [DATA_W-1:0] val;
    val = mem_q[rn];
    if (BYPASS) begin
      if (WE0 && (WN0 == rn)) begin
        val = WD0;
      end else if (WE1 && (WN1 == rn)) begin
        val = WD1;
      end
    end
    if (!run || (rn == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  // Mark is deliberately not bypassed: a producer issued this cycle only
  // becomes visible as busy from the next cycle.
  function automatic logic readBusy(input logic [ADDR_W-1:0] rn);
    logic b;
    b = busy_q[rn];
    if (BYPASS && ((WE0 && (WN0 == rn)) || (WE1 && (WN1 == rn)))) begin
      b = 1'b0;
    end
    if (!run || (rn == '0)) begin
      b = 1'b0;
    end
    return b;
  endfunction

  always_comb begin
    RD1   = readData(RN1);
    RD2   = readData(RN2);
    Busy1 = readBusy(RN1);
    Busy2 = readBusy(RN2);
    Ready = run;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb. Two instances (bypass on and off) share the same
// stimulus; a queue-based scoreboard compares their outputs against a
// behavioural model of the register file.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] RN1, RN2, WN0, WN1, MN;
  logic [DW-1:0] WD0, WD1;
  logic          WE0, WE1, Mark;

  logic [DW-1:0] rd1B, rd2B, rd1N, rd2N;
  logic          busy1B, busy2B, busy1N, busy2N, readyB, readyN;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dutByp (
    .clk(clk), .reset(reset), .RN1(RN1), .RN2(RN2), .RD1(rd1B), .RD2(rd2B),
    .Busy1(busy1B), .Busy2(busy2B), .WE0(WE0), .WN0(WN0), .WD0(WD0),
    .WE1(WE1), .WN1(WN1), .WD1(WD1), .Mark(Mark), .MN(MN), .Ready(readyB)
  );

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dutNob (
    .clk(clk), .reset(reset), .RN1(RN1), .RN2(RN2), .RD1(rd1N), .RD2(rd2N),
    .Busy1(busy1N), .Busy2(busy2N), .WE0(WE0), .WN0(WN0), .WD0(WD0),
    .WE1(WE1), .WN1(WN1), .WD1(WD1), .Mark(Mark), .MN(MN), .Ready(readyN)
  );

  typedef struct packed {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          busy1;
    logic          busy2;
    logic          ready;
  } obs_t;

  typedef struct packed {
    obs_t byp;
    obs_t nob;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: register contents, busy flags, clearing progress.
  logic [DW-1:0] mMem [DEPTH];
  bit            mBusy [DEPTH];
  bit            mReady = 1'b0;
  bit            mKnown = 1'b0;
  int            mInitIdx = 0;

  function automatic logic [DW-1:0] predRd(input logic [AW-1:0] rn, input bit byp);
    if (rn == 0) return '0;
    if (byp && WE0 && WN0 == rn) return WD0;
    if (byp && WE1 && WN1 == rn) return WD1;
    return mMem[rn];
  endfunction

  function automatic logic predBusy(input logic [AW-1:0] rn, input bit byp);
    if (rn == 0) return 1'b0;
    if (byp && ((WE0 && WN0 == rn) || (WE1 && WN1 == rn))) return 1'b0;
    return mBusy[rn];
  endfunction

  function automatic obs_t predict(input bit byp);
    obs_t o;
    o = '0;
    o.ready = mReady;
    if (mReady) begin
      o.rd1   = predRd(RN1, byp);
      o.rd2   = predRd(RN2, byp);
      o.busy1 = predBusy(RN1, byp);
      o.busy2 = predBusy(RN2, byp);
    end
    return o;
  endfunction

  // Model of one clock edge using the inputs currently applied.
  task automatic modelEdge();
    if (reset) begin
      mKnown   = 1'b1;
      mReady   = 1'b0;
      mInitIdx = 0;
      foreach (mBusy[i]) mBusy[i] = 1'b0;
    end else if (mKnown && !mReady) begin
      mMem[mInitIdx] = '0;
      mInitIdx++;
      if (mInitIdx == DEPTH) mReady = 1'b1;
    end else if (mKnown) begin
      // port 1 first so that port 0 overwrites it on a shared address
      if (WE1 && WN1 != 0) begin mMem[WN1] = WD1; mBusy[WN1] = 1'b0; end
      if (WE0 && WN0 != 0) begin mMem[WN0] = WD0; mBusy[WN0] = 1'b0; end
      if (Mark && MN != 0) mBusy[MN] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the model.
  task automatic applyStimulus(input logic rst, input logic [AW-1:0] rn1, input logic [AW-1:0] rn2,
                               input logic we0, input logic [AW-1:0] wn0, input logic [DW-1:0] wd0,
                               input logic we1, input logic [AW-1:0] wn1, input logic [DW-1:0] wd1,
                               input logic mark, input logic [AW-1:0] mn);
    exp_t e;
    reset = rst; RN1 = rn1; RN2 = rn2;
    WE0 = we0; WN0 = wn0; WD0 = wd0;
    WE1 = we1; WN1 = wn1; WD1 = wd1;
    Mark = mark; MN = mn;
    if (mKnown) begin
      e.byp = predict(1'b1);
      e.nob = predict(1'b0);
      expQ.push_back(e);
    end
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] rn1, input logic [AW-1:0] rn2);
    applyStimulus(1'b0, rn1, rn2, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic checkField(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input obs_t req, input logic [DW-1:0] rd1,
                             input logic [DW-1:0] rd2, input logic b1, input logic b2, input logic rdy);
    checkField({tag, ".RD1"},   rd1, req.rd1);
    checkField({tag, ".RD2"},   rd2, req.rd2);
    checkField({tag, ".Busy1"}, {31'd0, b1},  {31'd0, req.busy1});
    checkField({tag, ".Busy2"}, {31'd0, b2},  {31'd0, req.busy2});
    checkField({tag, ".Ready"}, {31'd0, rdy}, {31'd0, req.ready});
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("byp", e.byp, rd1B, rd2B, busy1B, busy2B, readyB);
      checkOutput("nob", e.nob, rd1N, rd2N, busy1N, busy2N, readyN);
    end
  end

  function automatic logic [AW-1:0] randAddr();
    // bias towards a few registers to provoke conflicts and bypass hits
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 5));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    reset = 1'b1; RN1 = '0; RN2 = '0; WE0 = 1'b0; WN0 = '0; WD0 = '0;
    WE1 = 1'b0; WN1 = '0; WD1 = '0; Mark = 1'b0; MN = '0;

    // first bring-up, then fill every register with garbage
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), 0);
    for (int i = 1; i < DEPTH; i++)
      applyStimulus(1'b0, AW'(i), 0, 1'b1, AW'(i), $urandom, 1'b0, 0, 0, 1'b1, AW'(i));

    // reset for two cycles, clearing walk with an ignored write to r5
    applyStimulus(1'b1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) applyStimulus(1'b0, 5, 6, 1'b1, 5, 32'hBAD0BAD0, 1'b0, 0, 0, 1'b1, 6);
      else        idle(5, AW'(i));
    end
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));

    // write priority and r0 protection
    applyStimulus(1'b0, 3, 0, 1'b1, 3, 32'h11111111, 1'b1, 3, 32'h22222222, 1'b0, 0);
    applyStimulus(1'b0, 3, 0, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 32'h12345678, 1'b1, 0);
    idle(3, 0);

    // bypass of port 1
    applyStimulus(1'b0, 7, 7, 1'b0, 0, 0, 1'b1, 7, 32'hDEADBEEF, 1'b0, 0);
    idle(7, 7);

    // scoreboard: mark, clear by write, mark beats write
    applyStimulus(1'b0, 9, 9, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 9);
    idle(9, 9);
    applyStimulus(1'b0, 9, 9, 1'b0, 0, 0, 1'b1, 9, 32'hCAFEF00D, 1'b0, 0);
    idle(9, 9);
    applyStimulus(1'b0, 9, 9, 1'b1, 9, 32'h0000ABCD, 1'b0, 0, 0, 1'b1, 9);
    idle(9, 9);

    // reset in RUN with r4 busy and holding 5
    applyStimulus(1'b0, 4, 0, 1'b1, 4, 32'h5, 1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 4, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 4);
    idle(4, 4);
    applyStimulus(1'b1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) idle(4, 4);

    // randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0), randAddr(), randAddr(),
                    ($urandom_range(0, 1) == 1), randAddr(), $urandom,
                    ($urandom_range(0, 1) == 1), randAddr(), $urandom,
                    ($urandom_range(0, 2) == 0), randAddr());
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: actual=%0d entries left required=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
